// File: rtl/regfile_wb_scoreboard.sv
// Write-port controller for the register file: round-robin writeback arbitration,
// one registered write per cycle, and a per-register busy scoreboard that stalls issue.
module regfile_wb_scoreboard #(
    parameter int NREG = 64,
    parameter int AW   = 6,
    parameter int DW   = 32,
    parameter int NREQ = 3
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               iss_valid,
    input  logic [AW-1:0]      iss_rs1,
    input  logic [AW-1:0]      iss_rs2,
    input  logic [AW-1:0]      iss_rd,
    input  logic               iss_wen,
    output logic               iss_stall,
    input  logic               flush,
    input  logic [NREQ-1:0]    wb_valid,
    output logic [NREQ-1:0]    wb_ready,
    input  logic [NREQ*AW-1:0] wb_rd,
    input  logic [NREQ*DW-1:0] wb_data,
    output logic               rf_we,
    output logic [AW-1:0]      rf_waddr,
    output logic [DW-1:0]      rf_wdata,
    output logic [NREG-1:0]    busy
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREG-1:0] busy_q, busy_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic            rf_we_q, rf_we_d;
    logic [AW-1:0]   rf_waddr_q, rf_waddr_d;
    logic [DW-1:0]   rf_wdata_q, rf_wdata_d;

    logic            gnt_found;
    logic [PW-1:0]   gnt_idx;
    logic [AW-1:0]   gnt_rd;
    logic [DW-1:0]   gnt_data;
    logic            iss_accept;

    // Handshake: a writeback transfers on the rising edge where wb_valid[i] & wb_ready[i];
    // the requester holds valid/rd/data stable until then. wb_ready does not wait on anything
    // downstream, so a valid requester is granted as soon as the rotating search reaches it.
    always_comb begin
        int idx;
        idx       = 0;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        gnt_rd    = '0;
        gnt_data  = '0;
        wb_ready  = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!gnt_found && wb_valid[idx]) begin
                gnt_found     = 1'b1;
                gnt_idx       = PW'(idx);
                gnt_rd        = wb_rd[idx*AW +: AW];
                gnt_data      = wb_data[idx*DW +: DW];
                wb_ready[idx] = 1'b1;
            end
        end
    end

    assign iss_stall  = iss_valid &
                        (busy_q[iss_rs1] | busy_q[iss_rs2] | (iss_wen & busy_q[iss_rd]));
    assign iss_accept = iss_valid & ~iss_stall;

    always_comb begin
        ptr_d = ptr_q;
        if (gnt_found) begin
            ptr_d = (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + PW'(1);
        end
    end

    // A granted rd=0 result completes the handshake but is never written.
    always_comb begin
        rf_we_d    = gnt_found && (gnt_rd != '0);
        rf_waddr_d = rf_we_d ? gnt_rd   : rf_waddr_q;
        rf_wdata_d = rf_we_d ? gnt_data : rf_wdata_q;
    end

    // Clear on commit, then set on issue so a same-edge set wins; flush overrides both.
    always_comb begin
        busy_d = busy_q;
        if (rf_we_q) busy_d[rf_waddr_q] = 1'b0;
        if (iss_accept && iss_wen && (iss_rd != '0)) busy_d[iss_rd] = 1'b1;
        if (flush) busy_d = '0;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            busy_q     <= '0;
            ptr_q      <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            busy_q     <= busy_d;
            ptr_q      <= ptr_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

    assign rf_we    = rf_we_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_regfile_wb_scoreboard.sv
// Directed bench for regfile_wb_scoreboard: expected register-file writes are queued by the
// stimulus and retired by a monitor; stall, busy and grant values are checked in place.
module tb_regfile_wb_scoreboard;

    localparam int NREG = 64;
    localparam int AW   = 6;
    localparam int DW   = 32;
    localparam int NREQ = 3;

    logic               clk = 1'b0;
    logic               rstn;
    logic               iss_valid;
    logic [AW-1:0]      iss_rs1, iss_rs2, iss_rd;
    logic               iss_wen;
    logic               iss_stall;
    logic               flush;
    logic [NREQ-1:0]    wb_valid;
    logic [NREQ-1:0]    wb_ready;
    logic [NREQ*AW-1:0] wb_rd;
    logic [NREQ*DW-1:0] wb_data;
    logic               rf_we;
    logic [AW-1:0]      rf_waddr;
    logic [DW-1:0]      rf_wdata;
    logic [NREG-1:0]    busy;

    logic [AW+DW-1:0] exp_q[$];
    int n_vec = 0;
    int n_err = 0;
    bit running = 1'b0;

    regfile_wb_scoreboard #(.NREG(NREG), .AW(AW), .DW(DW), .NREQ(NREQ)) dut (
        .clk(clk), .rstn(rstn),
        .iss_valid(iss_valid), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_rd(iss_rd),
        .iss_wen(iss_wen), .iss_stall(iss_stall), .flush(flush),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .busy(busy)
    );

    // Clock / reset: posedges at 5, 15, 25, ...
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_issue(input logic v, input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                               input logic [AW-1:0] rd, input logic wen);
        iss_valid = v;
        iss_rs1   = rs1;
        iss_rs2   = rs2;
        iss_rd    = rd;
        iss_wen   = wen;
    endtask

    task automatic drive_wb(input int i, input logic [AW-1:0] rd, input logic [DW-1:0] data);
        wb_rd[i*AW +: AW]   = rd;
        wb_data[i*DW +: DW] = data;
    endtask

    task automatic expect_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        exp_q.push_back({a, d});
    endtask

    // Monitor: retires queued writes and checks grant shape mid-cycle.
    always @(negedge clk) begin
        if (running && rstn) begin
            if (rf_we) begin
                logic [AW+DW-1:0] e;
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", {rf_waddr, rf_wdata}, '0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rf_write", {rf_waddr, rf_wdata}, e);
                end
            end
            chk("ready_onehot0_within_valid",
                64'($onehot0(wb_ready) && ((wb_ready & ~wb_valid) == '0)
                    && ((wb_valid == '0) == (wb_ready == '0))), 64'd1);
        end
    end

    initial begin
        rstn     = 1'b0;
        flush    = 1'b0;
        wb_valid = '0;
        wb_rd    = '0;
        wb_data  = '0;
        drive_issue(1'b0, '0, '0, '0, 1'b0);
        #2;
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_rf_we", 64'(rf_we), 64'd0);
        chk("reset_waddr_wdata", {26'd0, rf_waddr, rf_wdata}, 64'd0);
        #10 rstn = 1'b1;
        running = 1'b1;

        // 1: RAW stall on rd=5, cleared one edge after the commit
        tick();
        drive_issue(1'b1, 6'd0, 6'd0, 6'd5, 1'b1);
        #1 chk("t1_issue_no_stall", 64'(iss_stall), 64'd0);
        tick();
        chk("t1_busy5_set", 64'(busy), 64'h20);
        drive_issue(1'b1, 6'd5, 6'd0, 6'd0, 1'b0);
        #1 chk("t1_raw_stall", 64'(iss_stall), 64'd1);
        drive_wb(0, 6'd5, 32'd21);
        wb_valid = 3'b001;
        expect_write(6'd5, 32'd21);
        #1 chk("t1_ready0", 64'(wb_ready), 64'b001);
        tick();
        wb_valid = '0;
        chk("t1_rf_we", 64'(rf_we), 64'd1);
        chk("t1_busy5_still_set", 64'(busy[5]), 64'd1);
        chk("t1_stall_during_commit", 64'(iss_stall), 64'd1);
        tick();
        chk("t1_busy5_cleared", 64'(busy[5]), 64'd0);
        chk("t1_unstall", 64'(iss_stall), 64'd0);
        chk("t1_rf_we_low", 64'(rf_we), 64'd0);
        drive_issue(1'b0, '0, '0, '0, 1'b0);

        // 2: fresh reset, all three requesters -> grants 0,1,2
        rstn = 1'b0;
        #2 rstn = 1'b1;
        drive_wb(0, 6'd1, 32'd10);
        drive_wb(1, 6'd2, 32'd20);
        drive_wb(2, 6'd3, 32'd30);
        wb_valid = 3'b111;
        expect_write(6'd1, 32'd10);
        expect_write(6'd2, 32'd20);
        expect_write(6'd3, 32'd30);
        #1 chk("t2_grant0", 64'(wb_ready), 64'b001);
        tick();
        wb_valid = 3'b110;
        #1 chk("t2_grant1", 64'(wb_ready), 64'b010);
        tick();
        wb_valid = 3'b100;
        #1 chk("t2_grant2", 64'(wb_ready), 64'b100);
        tick();
        wb_valid = '0;
        tick();

        // 3: req0 and req2 held valid -> 0,2,0,2, req1 never granted
        drive_wb(0, 6'd4, 32'd40);
        drive_wb(2, 6'd6, 32'd60);
        wb_valid = 3'b101;
        for (int k = 0; k < 4; k++) begin
            #1 chk("t3_alternate", 64'(wb_ready), (k % 2 == 0) ? 64'b001 : 64'b100);
            if (k % 2 == 0) expect_write(6'd4, 32'd40);
            else            expect_write(6'd6, 32'd60);
            tick();
        end
        wb_valid = '0;
        tick();

        // 4: rd=0 is never busy and never written
        drive_issue(1'b1, 6'd0, 6'd0, 6'd0, 1'b1);
        #1 chk("t4_no_stall_rd0", 64'(iss_stall), 64'd0);
        tick();
        drive_issue(1'b0, '0, '0, '0, 1'b0);
        chk("t4_busy_zero", 64'(busy), 64'd0);
        drive_wb(1, 6'd0, 32'd128);
        wb_valid = 3'b010;
        #1 chk("t4_ready1", 64'(wb_ready), 64'b010);
        tick();
        wb_valid = '0;
        chk("t4_rf_we_stays_low", 64'(rf_we), 64'd0);

        // 5: flush beats a same-cycle issue; the in-flight write still lands
        drive_issue(1'b1, 6'd0, 6'd0, 6'd1, 1'b1);
        tick();
        drive_issue(1'b1, 6'd0, 6'd0, 6'd5, 1'b1);
        tick();
        chk("t5_busy_1_5", 64'(busy), 64'h22);
        drive_issue(1'b1, 6'd0, 6'd0, 6'd7, 1'b1);
        flush = 1'b1;
        drive_wb(0, 6'd1, 32'd200);
        wb_valid = 3'b001;
        expect_write(6'd1, 32'd200);
        #1 chk("t5_no_stall_rd7", 64'(iss_stall), 64'd0);
        chk("t5_ready0", 64'(wb_ready), 64'b001);
        tick();
        flush    = 1'b0;
        wb_valid = '0;
        drive_issue(1'b0, '0, '0, '0, 1'b0);
        chk("t5_busy_flushed", 64'(busy), 64'd0);
        chk("t5_write_after_flush", {31'd0, rf_we, 26'd0, rf_waddr}, {31'd0, 1'b1, 26'd0, 6'd1});
        tick();
        chk("t5_busy_still_zero", 64'(busy), 64'd0);

        // 6: async reset mid-cycle drops an in-flight write
        drive_issue(1'b1, 6'd0, 6'd0, 6'd3, 1'b1);
        tick();
        drive_issue(1'b0, '0, '0, '0, 1'b0);
        chk("t6_busy3_set", 64'(busy), 64'h8);
        drive_wb(1, 6'd3, 32'd33);
        wb_valid = 3'b010;
        #1 chk("t6_ready1", 64'(wb_ready), 64'b010);
        tick();
        wb_valid = '0;
        chk("t6_rf_we_inflight", 64'(rf_we), 64'd1);
        #1 rstn = 1'b0;
        #1 chk("t6_rf_we_dropped", 64'(rf_we), 64'd0);
        chk("t6_busy_cleared", 64'(busy), 64'd0);
        chk("t6_waddr_reset", 64'(rf_waddr), 64'd0);
        #1 rstn = 1'b1;
        drive_wb(2, 6'd9, 32'd99);
        wb_valid = 3'b100;
        expect_write(6'd9, 32'd99);
        #1 chk("t6_ready2_after_reset", 64'(wb_ready), 64'b100);
        tick();
        wb_valid = 3'b011;
        drive_wb(0, 6'd10, 32'd100);
        drive_wb(1, 6'd11, 32'd110);
        expect_write(6'd10, 32'd100);
        #1 chk("t6_ptr_wrapped_to0", 64'(wb_ready), 64'b001);
        tick();
        wb_valid = '0;
        tick();
        tick();

        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        running = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/regfile_wb_scoreboard.md
Name: regfile_wb_scoreboard

Overview:
- Write-port controller for the 64x32 register file.
- Arbitrates one register-file write port between NREQ writeback sources (ALU, FPU, load unit) using valid/ready and round-robin.
- Keeps a per-register busy scoreboard and stalls issue on RAW and WAW hazards.
- Sits between the issue stage / execution units and the register file's write inputs (WriteReg, WriteData, RegWrite).

Parameters:
- NREG, 64, number of architectural registers
- AW, 6, register address width
- DW, 32, data width
- NREQ, 3, number of writeback requesters

Ports:
- clk  in  1  clock, all state on rising edge
- rstn  in  1  reset, asynchronous, active-low
- iss_valid  in  1  issue stage presents an instruction
- iss_rs1  in  AW  source register 1
- iss_rs2  in  AW  source register 2
- iss_rd  in  AW  destination register
- iss_wen  in  1  instruction writes rd
- iss_stall  out  1  combinational; issue must hold
- flush  in  1  synchronous clear of all busy bits
- wb_valid  in  NREQ  requester i has a result
- wb_ready  out  NREQ  combinational grant, one-hot or zero
- wb_rd  in  NREQ*AW  requester i address at [i*AW +: AW]
- wb_data  in  NREQ*DW  requester i data at [i*DW +: DW]
- rf_we  out  1  register-file write enable (registered)
- rf_waddr  out  AW  register-file write address (registered)
- rf_wdata  out  DW  register-file write data (registered)
- busy  out  NREG  scoreboard state

Behaviour:
- Reset (rstn low, takes effect immediately, no clock needed):
  - busy=0, rf_we=0, rf_waddr=0, rf_wdata=0.
  - Round-robin pointer p=0.
- Stall:
  - iss_stall = iss_valid & (busy[rs1] | busy[rs2] | (iss_wen & busy[rd])).
  - Register 0 is never busy.
- Issue:
  - An instruction is accepted when iss_valid & !iss_stall.
  - If accepted with iss_wen=1 and rd!=0, busy[rd] is set at that edge.
- Arbitration:
  - Search order is p, p+1, … mod NREQ; the first requester with valid=1 gets wb_ready=1; all others get 0.
  - Transfer occurs on valid&ready at the edge.
  - After a grant to requester i, p becomes (i+1) mod NREQ. With no grant, p is unchanged.
  - Requesters hold valid, rd and data stable until granted.
- Write latency:
  - A transfer at edge N drives rf_we=1 with rf_waddr=wb_rd and rf_wdata=wb_data during cycle N..N+1. The register file commits at edge N+1.
  - If no transfer occurs at edge N, rf_we=0 in the following cycle, and rf_waddr/rf_wdata hold their previous values.
  - Throughput is one write per cycle.
- rd=0 writeback:
  - The handshake completes normally and the grant consumes p.
  - rf_we stays 0 and busy is untouched.
- Busy clear:
  - busy[rf_waddr] clears at the edge where rf_we=1 (the commit edge). A dependent issue therefore unstalls in the cycle after commit and reads committed data.
- Simultaneous set and clear of the same register on the same edge:
  - The set wins.
  - This is unreachable in normal flow, because busy[rd] stalls any re-issue to that rd.
- Writeback to a non-busy register: the write is still performed and busy stays 0.
- flush:
  - Clears all busy bits at the next edge and has priority over an issue set on that edge.
  - An issue accepted in the flush cycle does not set busy.
  - In-flight writebacks and rf_we are unaffected; p is kept.
- Reset asserted mid-operation: all state goes to reset values immediately, and any in-flight rf_we is dropped.

Test Plan:
1. Issue rd=5 wen=1 → busy[5]=1. Issue rs1=5 → iss_stall=1. Req0 writes rd=5 data=21 at edge N → rf_we=1, waddr=5, wdata=21 in cycle N. busy[5]=0 after edge N+1, then iss_stall=0.
2. After reset, req0/1/2 all valid with rd 1/2/3, data 10/20/30 → grants 0,1,2 on consecutive edges. rf writes 1/10, 2/20, 3/30 on the following three cycles.
3. Req0 and req2 held continuously valid → grant sequence 0,2,0,2. Req1 (idle) is never granted; wb_ready is never more than one-hot.
4. Issue rd=0 wen=1 → busy[0]=0, no stall. Req1 writes rd=0 data=128 → wb_ready[1]=1, rf_we stays 0.
5. busy[1] and busy[5] set, flush=1 together with an issue of rd=7 → busy all 0 next edge, including bit 7. A pending writeback to rd=1 data=200 still produces rf_we=1, waddr=1, wdata=200.
6. rstn driven low between edges while rf_we=1 and busy[3]=1 → rf_we=0 and busy=0 immediately. After release, req2-only valid is granted only when the p=0 search reaches it, and wb_ready is correct.
